// File: rtl/jk_bank_loader.sv
// jk_bank_loader: drives J/K commands into an external JK flip-flop bank until
// its Q matches a requested target word, retrying up to MAX_RETRY extra times.
// Optional build macro: JK_BANK_LOADER_TOGGLE_EN (mismatched bits toggle, J=K=1).
module jk_bank_loader #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned MAX_RETRY = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] target,
   input  logic [WIDTH-1:0] q_fb,
   output logic [WIDTH-1:0] j,
   output logic [WIDTH-1:0] k,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [3:0]       attempts
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      CHECK = 2'd2,
      FIN   = 2'd3
   } state_t;

   // One spare bit so MAX_RETRY=15 cannot wrap the counter back into range.
   localparam logic [4:0] MAX_R = 5'(MAX_RETRY);

   state_t           state, state_nx;
   logic [WIDTH-1:0] tgt_r, tgt_nx;
   logic [WIDTH-1:0] j_nx, k_nx;
   logic [WIDTH-1:0] cmd_t, cmd_j, cmd_k;
   logic             err_nx;
   logic [4:0]       cnt, cnt_nx;

   // Per-bit command from the wanted word (fresh target in IDLE, latched otherwise) and bank Q.
   always_comb begin
      cmd_t = (state == IDLE) ? target : tgt_r;
`ifdef JK_BANK_LOADER_TOGGLE_EN
      cmd_j = cmd_t ^ q_fb;
      cmd_k = cmd_t ^ q_fb;
`else
      cmd_j = cmd_t & ~q_fb;
      cmd_k = ~cmd_t & q_fb;
`endif
   end

   // Next-state and next-output logic; j/k default to hold so they are nonzero only in DRIVE.
   always_comb begin
      state_nx = state;
      tgt_nx   = tgt_r;
      j_nx     = '0;
      k_nx     = '0;
      err_nx   = err;
      cnt_nx   = cnt;
      case (state)
         IDLE: begin
            if (start) begin
               tgt_nx   = target;
               err_nx   = 1'b0;
               j_nx     = cmd_j;
               k_nx     = cmd_k;
               cnt_nx   = 5'd1;
               state_nx = DRIVE;
            end
         end
         DRIVE: begin
            state_nx = CHECK;
         end
         CHECK: begin
            if (q_fb == tgt_r) begin
               state_nx = FIN;
            end else if (cnt <= MAX_R) begin
               j_nx     = cmd_j;
               k_nx     = cmd_k;
               cnt_nx   = cnt + 5'd1;
               state_nx = DRIVE;
            end else begin
               err_nx   = 1'b1;
               state_nx = FIN;
            end
         end
         FIN: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // State and registered outputs, synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         tgt_r <= '0;
         j     <= '0;
         k     <= '0;
         err   <= 1'b0;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         tgt_r <= tgt_nx;
         j     <= j_nx;
         k     <= k_nx;
         err   <= err_nx;
         cnt   <= cnt_nx;
      end
   end

   assign busy     = (state == DRIVE) || (state == CHECK);
   assign done     = (state == FIN);
   assign attempts = cnt[4] ? 4'hF : cnt[3:0];

endmodule

// File: tb/tb_jk_bank_loader.sv
// Testbench for jk_bank_loader: behavioural JK bank with stuck-bit injection,
// table of load operations checked through an expected-result queue.
module tb_jk_bank_loader;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] target;
   logic [7:0] q_fb;
   logic [7:0] j, k;
   logic       busy, done, err;
   logic [3:0] attempts;

   logic [7:0] bank_q;
   logic [7:0] bank_nx;
   logic [7:0] preload_val;
   logic       preload_en;
   logic [7:0] stuck_mask;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [7:0] q_init;
      logic [7:0] tgt;
      logic [7:0] stuck;
      logic [7:0] exp_j;
      logic [7:0] exp_k;
      logic       exp_err;
      logic [3:0] exp_att;
      logic [7:0] exp_q;
      int         exp_lat;
      int         exp_nz;
   } vec_t;

   vec_t vecs[5];
   vec_t sb[$];

   jk_bank_loader #(.WIDTH(8), .MAX_RETRY(3)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .target   (target),
      .q_fb     (q_fb),
      .j        (j),
      .k        (k),
      .busy     (busy),
      .done     (done),
      .err      (err),
      .attempts (attempts)
   );

   always #5 clk = ~clk;

   assign q_fb = bank_q;

   // External JK bank model; stuck bits read back as 0.
   always @(posedge clk) begin
      bank_nx = bank_q;
      if (preload_en) begin
         bank_nx = preload_val;
      end else begin
         for (int i = 0; i < 8; i++) begin
            case ({j[i], k[i]})
               2'b01:   bank_nx[i] = 1'b0;
               2'b10:   bank_nx[i] = 1'b1;
               2'b11:   bank_nx[i] = ~bank_q[i];
               default: bank_nx[i] = bank_q[i];
            endcase
         end
      end
      bank_q <= bank_nx & ~stuck_mask;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [7:0] val, input logic [7:0] stuck);
      preload_val = val;
      stuck_mask  = stuck;
      preload_en  = 1'b1;
      tick();
      preload_en  = 1'b0;
   endtask

   // Wait for done with a cycle bound; returns cycles since acceptance and count of nonzero j/k cycles.
   task automatic wait_done(input int first_nz, output int cyc, output int nz, output logic back2back);
      logic prev, cur;
      cyc       = 1;
      nz        = first_nz;
      prev      = (first_nz != 0);
      back2back = 1'b0;
      while (!done && cyc < 40) begin
         tick();
         cyc++;
         cur = ((j | k) != 8'h00);
         if (cur) nz++;
         if (cur && prev) back2back = 1'b1;
         prev = cur;
      end
      chk("done_seen", done, 1'b1);
   endtask

   task automatic run_vec(input vec_t v);
      vec_t e;
      int   cyc, nz;
      logic b2b;
      preload(v.q_init, v.stuck);
      start  = 1'b1;
      target = v.tgt;
      sb.push_back(v);
      tick();
      start  = 1'b0;
      target = 8'h00;
      chk("drive_busy", busy, 1'b1);
      chk("drive_j", j, v.exp_j);
      chk("drive_k", k, v.exp_k);
      wait_done(((j | k) != 8'h00) ? 1 : 0, cyc, nz, b2b);
      e = sb.pop_front();
      chk("latency", cyc, e.exp_lat);
      chk("fin_busy", busy, 1'b0);
      chk("err", err, e.exp_err);
      chk("attempts", attempts, e.exp_att);
      chk("bank_q", bank_q, e.exp_q);
      chk("nz_drives", nz, e.exp_nz);
      chk("jk_back2back", b2b, 1'b0);
      tick();
      chk("done_pulse", done, 1'b0);
      chk("attempts_hold", attempts, e.exp_att);
   endtask

   initial begin
      int   cyc, nz;
      logic b2b;

      //              q_init tgt    stuck  j      k      err   att    q      lat nz
`ifdef JK_BANK_LOADER_TOGGLE_EN
      vecs[0] = '{8'h00, 8'hA5, 8'h00, 8'hA5, 8'hA5, 1'b0, 4'd1, 8'hA5, 3, 1};
      vecs[1] = '{8'hF0, 8'h3C, 8'h00, 8'hCC, 8'hCC, 1'b0, 4'd1, 8'h3C, 3, 1};
      vecs[2] = '{8'h5A, 8'h5A, 8'h00, 8'h00, 8'h00, 1'b0, 4'd1, 8'h5A, 3, 0};
      vecs[3] = '{8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 1'b1, 4'd4, 8'h00, 9, 4};
      vecs[4] = '{8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF, 1'b0, 4'd1, 8'h00, 3, 1};
`else
      vecs[0] = '{8'h00, 8'hA5, 8'h00, 8'hA5, 8'h00, 1'b0, 4'd1, 8'hA5, 3, 1};
      vecs[1] = '{8'hF0, 8'h3C, 8'h00, 8'h0C, 8'hC0, 1'b0, 4'd1, 8'h3C, 3, 1};
      vecs[2] = '{8'h5A, 8'h5A, 8'h00, 8'h00, 8'h00, 1'b0, 4'd1, 8'h5A, 3, 0};
      vecs[3] = '{8'h00, 8'h01, 8'h01, 8'h01, 8'h00, 1'b1, 4'd4, 8'h00, 9, 4};
      vecs[4] = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF, 1'b0, 4'd1, 8'h00, 3, 1};
`endif

      rst         = 1'b1;
      start       = 1'b0;
      target      = 8'h00;
      preload_en  = 1'b0;
      preload_val = 8'h00;
      stuck_mask  = 8'h00;
      bank_q      = 8'h00;
      tick();
      tick();
      chk("rst_j", j, 8'h00);
      chk("rst_k", k, 8'h00);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_err", err, 1'b0);
      chk("rst_attempts", attempts, 4'd0);
      rst = 1'b0;
      tick();

      for (int unsigned i = 0; i < 5; i++) begin
         run_vec(vecs[i]);
      end

      // Reset asserted during DRIVE, after an op that left err=1 and attempts=4.
      run_vec(vecs[3]);
      preload(8'h00, 8'h00);
      start  = 1'b1;
      target = 8'hA5;
      tick();
      start  = 1'b0;
      chk("mid_drive_j", j, 8'hA5);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_j", j, 8'h00);
      chk("mid_rst_k", k, 8'h00);
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_done", done, 1'b0);
      chk("mid_rst_err", err, 1'b0);
      chk("mid_rst_attempts", attempts, 4'd0);
      tick();
      chk("mid_rst_idle", busy, 1'b0);

      // start held high: second target ignored while busy, accepted only in the IDLE after FIN.
      preload(8'h00, 8'h00);
      start  = 1'b1;
      target = 8'hA5;
      tick();
      target = 8'hFF;
      chk("b2b_first_j", j, 8'hA5);
      wait_done(1, cyc, nz, b2b);
      chk("b2b_first_lat", cyc, 3);
      chk("b2b_first_q", bank_q, 8'hA5);
      tick();
      chk("b2b_fin_not_accepted", busy, 1'b0);
      chk("b2b_idle_done", done, 1'b0);
      tick();
      start = 1'b0;
      chk("b2b_second_busy", busy, 1'b1);
`ifdef JK_BANK_LOADER_TOGGLE_EN
      chk("b2b_second_j", j, 8'h5A);
      chk("b2b_second_k", k, 8'h5A);
`else
      chk("b2b_second_j", j, 8'h5A);
      chk("b2b_second_k", k, 8'h00);
`endif
      wait_done(1, cyc, nz, b2b);
      chk("b2b_second_lat", cyc, 3);
      chk("b2b_second_q", bank_q, 8'hFF);
      chk("b2b_second_err", err, 1'b0);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
